alu_control_md: RTL and testbench

- Parametrised successor to the single-cycle ALU control decoder.
- Decodes aluop/funct into the 4-bit ALU selector exactly as before, and adds a WIDTH-generic iterative multiply/divide sequencer with HI/LO registers.
- Adds a stall handshake so the multi-cycle datapath can hold issue while a mult/div is in flight.
- Sits between the main control unit and the ALU/register-file write mux.

---
 rtl/alu_control_md.sv | 215 +++++++++++++++++++++
 tb/tb_alu_control_md.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_md.sv
// alu_control_md: ALU control decoder with an iterative multiply/divide unit.
//
// Purpose:
//   Decodes aluop/funct into the 4-bit ALU selector. Also contains a WIDTH-generic
//   shift-add multiplier and restoring divider, each producing one bit per cycle,
//   with HI/LO result registers. A stall handshake holds issue while an operation
//   is in flight.
//
// Optional feature:
//   SIGNED_MD_EN - when defined, MULT/DIV treat a/b as two's complement.
//                  Undefined (default): fully unsigned.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   valid  in   instruction issued this cycle
//   aluop  in   [1:0] operation class from main control
//   opf    in   [5:0] funct field
//   a, b   in   [WIDTH-1:0] rs / rt operands
//   ops    out  [3:0] ALU selector (combinational)
//   stall  out  hold the pipeline (combinational)
//   busy   out  mult/div in flight (registered)
//   done   out  one-cycle pulse when hi/lo are updated (registered)
//   hi, lo out  [WIDTH-1:0] HI / LO registers
module alu_control_md #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [1:0]       aluop,
  input  logic [5:0]       opf,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       ops,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] OpfMult = 6'b011000;
  localparam logic [5:0] OpfDiv  = 6'b011010;
  localparam logic [5:0] OpfMfhi = 6'b010000;
  localparam logic [5:0] OpfMflo = 6'b010010;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

  state_e             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;    // mul: {partial, multiplier}; div: {rem, quot}
  logic [WIDTH-1:0]   opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic               md_req, md_div, hilo_rd;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, rem_sh, div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  // ---------------------------------------------------------------- decode
  always_comb begin
    ops = 4'b1111;
    unique case (aluop)
      2'b00: ops = 4'b0010;
      2'b01: ops = 4'b0110;
      2'b11: ops = 4'b0001;
      2'b10: begin
        case (opf)
          6'b100100: ops = 4'b0000;
          6'b100101: ops = 4'b0001;
          6'b100000: ops = 4'b0010;
          6'b000010: ops = 4'b0011;
          6'b100010: ops = 4'b0110;
          6'b101010: ops = 4'b0111;
          6'b100111: ops = 4'b1100;
          OpfMfhi:   ops = 4'b1000;
          OpfMflo:   ops = 4'b1001;
          default:   ops = 4'b1111;
        endcase
      end
    endcase
  end

  assign md_req  = valid & (aluop == 2'b10) & ((opf == OpfMult) | (opf == OpfDiv));
  assign md_div  = (opf == OpfDiv);
  assign hilo_rd = valid & (aluop == 2'b10) & ((opf == OpfMfhi) | (opf == OpfMflo));
  assign stall   = busy_q & (md_req | hilo_rd);

  // ---------------------------------------------------------------- sign handling
`ifdef SIGNED_MD_EN
  logic neg_q, neg_d;    // product / quotient sign
  logic rneg_q, rneg_d;  // remainder sign (dividend's)
  logic dz_q, dz_d;      // divide by zero: quotient stays all ones

  assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  // ---------------------------------------------------------------- sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = rem_sh - {1'b0, opnd_q};

    prod = acc_q;
    quot = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
`ifdef SIGNED_MD_EN
    neg_d  = neg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    if (neg_q) prod = ~acc_q + 1'b1;
    if (neg_q && !dz_q) quot = ~quot + 1'b1;
    if (rneg_q) rem = ~rem + 1'b1;
`endif

    unique case (state_q)
      StIdle: begin
        if (md_req) begin
          state_d = md_div ? StDiv : StMul;
          cnt_d   = '0;
          busy_d  = 1'b1;
          acc_d   = {{WIDTH{1'b0}}, (md_div ? a_mag : b_mag)};
          opnd_d  = md_div ? b_mag : a_mag;
`ifdef SIGNED_MD_EN
          neg_d  = a[WIDTH-1] ^ b[WIDTH-1];
          rneg_d = a[WIDTH-1];
          dz_d   = (b == '0);
`endif
        end
      end
      StMul: begin
        if (cnt_q == CNTW'(WIDTH)) begin
          state_d = StFin;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = prod[2*WIDTH-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDiv: begin
        if (cnt_q == CNTW'(WIDTH)) begin
          state_d = StFin;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = rem;
          lo_d    = quot;
        end else begin
          // Trial subtract; keep the shifted remainder when it borrows.
          if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                  acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFin: state_d = StIdle;  // a request seen here is taken in the next idle cycle
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SIGNED_MD_EN
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SIGNED_MD_EN
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_control_md.sv
// tb_alu_control_md: self-checking bench for alu_control_md (WIDTH = 32).
// Covers decode, MULT/DIV results and latency, divide by zero, stall handshake,
// requests during busy/FIN, and reset in the middle of an operation.
module tb_alu_control_md;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, valid;
  logic [1:0]   aluop;
  logic [5:0]   opf;
  logic [W-1:0] a, b;
  logic [3:0]   ops;
  logic         stall, busy, done;
  logic [W-1:0] hi, lo;

  int ncomp = 0;
  int nfail = 0;

  alu_control_md #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .aluop (aluop),
    .opf   (opf),
    .a     (a),
    .b     (b),
    .ops   (ops),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] MULT = 6'b011000;
  localparam logic [5:0] DIV  = 6'b011010;
  localparam logic [5:0] MFLO = 6'b010010;
  localparam logic [5:0] ADD  = 6'b100000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference selector from the decode table.
  function automatic logic [3:0] ref_ops(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0001;
    case (f)
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100000: return 4'b0010;
      6'b000010: return 4'b0011;
      6'b100010: return 4'b0110;
      6'b101010: return 4'b0111;
      6'b100111: return 4'b1100;
      6'b010000: return 4'b1000;
      6'b010010: return 4'b1001;
      default:   return 4'b1111;
    endcase
  endfunction

  // Reference {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_md(input logic is_div, input logic [31:0] x,
                                         input logic [31:0] y);
`ifdef SIGNED_MD_EN
    longint sx, sy, p;
    sx = $signed(x);
    sy = $signed(y);
    if (!is_div) begin
      p = sx * sy;
      return p;
    end
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    return {32'(sx % sy), 32'(sx / sy)};
`else
    logic [63:0] ux, uy;
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (!is_div) return ux * uy;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    return {32'(ux % uy), 32'(ux / uy)};
`endif
  endfunction

  // Bounded wait for done; n = edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Issue one op, follow it to completion, check latency, busy, hi/lo and the done pulse.
  task automatic run_md(input logic is_div, input logic [31:0] x, input logic [31:0] y,
                        input string tag);
    logic [63:0] exp;
    logic [31:0] h0, l0;
    logic        ok;
    int          n;
    exp   = ref_md(is_div, x, y);
    valid = 1'b1;
    aluop = 2'b10;
    opf   = is_div ? DIV : MULT;
    a     = x;
    b     = y;
    #1;
    chk({tag, "_issue_stall"}, 64'(stall), 64'd0);
    tick();  // accepted on this edge
    valid = 1'b0;
    a     = $urandom;  // operands must already be captured
    b     = $urandom;
    h0 = hi;
    l0 = lo;
    ok = 1'b1;
    n  = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy !== 1'b1 || hi !== h0 || lo !== l0) ok = 1'b0;
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(W + 1));
    chk({tag, "_busy_hold"}, 64'(ok), 64'd1);
    chk({tag, "_hilo"}, {hi, lo}, exp);
    chk({tag, "_busy_fin"}, 64'(busy), 64'd0);
    tick();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  logic [1:0]  dec_aluop [11] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                                  2'b00, 2'b01, 2'b11};
  logic [5:0]  dec_opf   [11] = '{6'b100100, 6'b100101, 6'b100000, 6'b100111, 6'b000010,
                                  6'b100010, 6'b101010, 6'b000000, 6'b000000, 6'b000000,
                                  6'b000000};
  logic [3:0]  dec_exp   [11] = '{4'b0000, 4'b0001, 4'b0010, 4'b1100, 4'b0011, 4'b0110,
                                  4'b0111, 4'b1111, 4'b0010, 4'b0110, 4'b0001};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e1, e2;
    logic [31:0] x, y;
    logic        d;
    int          n;

    rst = 1'b1; valid = 1'b0; aluop = 2'b00; opf = 6'd0; a = '0; b = '0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;

    // Directed decode table, then random aluop/opf against the reference table.
    for (int i = 0; i < 11; i++) begin
      aluop = dec_aluop[i];
      opf   = dec_opf[i];
      #1;
      chk($sformatf("dec_%0d", i), 64'(ops), 64'(dec_exp[i]));
    end
    for (int i = 0; i < 16; i++) begin
      aluop = 2'($urandom_range(0, 3));
      opf   = 6'($urandom);
      #1;
      chk($sformatf("dec_rnd_%0d", i), 64'(ops), 64'(ref_ops(aluop, opf)));
    end
    tick();

    // Directed mult/div.
    run_md(1'b0, 32'h0001_0000, 32'h0003_0000, "mult_shift");
    chk("mult_shift_const", {hi, lo}, 64'h0000_0003_0000_0000);
    run_md(1'b1, 32'd100, 32'd7, "div_100_7");
    chk("div_100_7_const", {hi, lo}, {32'd2, 32'd14});
    run_md(1'b1, 32'd100, 32'd0, "div_by_zero");
    chk("div_by_zero_const", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
    run_md(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_max");
    run_md(1'b1, 32'hFFFF_FFFF, 32'd1, "div_by_one");
    run_md(1'b1, 32'd5, 32'd9, "div_small");
`ifdef SIGNED_MD_EN
    run_md(1'b0, 32'hFFFF_FFFD, 32'd5, "smult_neg3_5");
    chk("smult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_md(1'b1, 32'hFFFF_FFF9, 32'd2, "sdiv_neg7_2");
    chk("sdiv_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_md(1'b1, 32'hFFFF_FFF9, 32'd0, "sdiv_zero");
`endif

    // Randomized operations.
    for (int i = 0; i < 12; i++) begin
      d = 1'($urandom_range(0, 1));
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      run_md(d, x, y, $sformatf("rnd_%0d", i));
    end

    // Stall handshake: MFLO and a second request are held while busy; ADD is not.
    x = 32'd123_456_789; y = 32'd987;
    e1 = ref_md(1'b0, x, y);
    e2 = ref_md(1'b1, 32'd1000, 32'd33);
    valid = 1'b1; aluop = 2'b10; opf = MULT; a = x; b = y;
    tick();
    opf = MFLO;
    #1;
    chk("stall_mflo", 64'(stall), 64'd1);
    chk("stall_mflo_ops", 64'(ops), 64'(4'b1001));
    opf = ADD;
    #1;
    chk("stall_add", 64'(stall), 64'd0);
    chk("stall_add_ops", 64'(ops), 64'(4'b0010));
    opf = DIV; a = 32'd1000; b = 32'd33;
    #1;
    chk("stall_md_busy", 64'(stall), 64'd1);
    wait_done(n);
    chk("stall_fin_done", 64'(done), 64'd1);
    chk("stall_fin_nostall", 64'(stall), 64'd0);
    chk("stall_undisturbed", {hi, lo}, e1);
    tick();
    chk("fin_req_not_taken", 64'(busy), 64'd0);
    tick();
    chk("idle_req_taken", 64'(busy), 64'd1);
    valid = 1'b0;
    wait_done(n);
    chk("reissued_div", {hi, lo}, e2);
    tick();

    // Reset in the middle of a divide.
    valid = 1'b1; aluop = 2'b10; opf = DIV; a = 32'd100; b = 32'd7;
    tick();
    valid = 1'b0;
    repeat (10) tick();
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    run_md(1'b0, 32'd6, 32'd7, "after_rst_mult");
    chk("after_rst_const", 64'(lo), 64'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
